rib_arbiter: RTL and testbench

Three-master, one-slave arbiter for the core memory bus: the JTAG debug master, the ex load/store port and the instruction-fetch port share one req/ready slave port (unified SRAM/bus). It sits between tinyriscv and the memory/peripheral interconnect and produces the pipeline hold flag consumed by ctrl.

---
 rtl/tinyriscv_pkg.sv | 26 ++
 rtl/rib_arb_prio.sv | 28 ++
 rtl/rib_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_rib_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyriscv_pkg.sv
// tinyriscv_pkg: shared bus types for the core memory bus and the enums
// used by the RIB arbiter.
//   MemAddrBus / MemBus : 32-bit address and data words
//   rib_owner_e         : current bus owner (NONE, DBG, EX, PC)
//   rib_arb_state_e     : arbiter FSM state (IDLE, BUSY)
package tinyriscv_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_W      = 32;

  typedef logic [MEM_ADDR_W-1:0] MemAddrBus;
  typedef logic [MEM_W-1:0]      MemBus;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DBG  = 2'd1,
    EX   = 2'd2,
    PC   = 2'd3
  } rib_owner_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rib_arb_state_e;

endpackage

// File: rtl/rib_arb_prio.sv
// rib_arb_prio: combinational priority pick for the RIB arbiter.
//   dbg_req_i, ex_req_i, pc_req_i : candidate requests
//   pc_first_i                    : rank PC above EX (DBG always highest)
//   grant_o                       : winning master, NONE when nobody requests
module rib_arb_prio
  import tinyriscv_pkg::*;
(
  input  logic       dbg_req_i,
  input  logic       ex_req_i,
  input  logic       pc_req_i,
  input  logic       pc_first_i,
  output rib_owner_e grant_o
);

  always_comb begin
    grant_o = NONE;
    if (dbg_req_i) begin
      grant_o = DBG;
    end else if (pc_first_i && pc_req_i) begin
      grant_o = PC;
    end else if (ex_req_i) begin
      grant_o = EX;
    end else if (pc_req_i) begin
      grant_o = PC;
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: three-master (debug, ex load/store, instruction fetch) to
// one-slave arbiter for the core memory bus. Fixed priority DBG > EX > PC,
// no preemption, one transaction in flight.
//
// Ports:
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   dbg_req_i/we/addr/wdata        : debug master request (held until ready)
//   ex_req_i/we/addr/wdata         : ex master request (held until ready)
//   pc_req_i/pc_addr_i             : fetch request, read-only
//   dbg/ex/pc_ready_o              : one-cycle completion pulse to owner
//   rdata_o                        : slave read data, non-zero only with a ready
//   s_req/we/addr/wdata_o          : slave request, driven from owner while BUSY
//   s_rdata_i, s_ready_i           : slave read data and completion pulse
//   hold_flag_o                    : pipeline hold while debug wants/owns bus
//
// Parameters:
//   STARVE_LIMIT    : consecutive EX grants tolerated while fetch waits (1..15)
//   ARB_IDLE_BUBBLE : 1 = idle cycle between transactions, 0 = back-to-back
//
// Optional feature macro: RIB_ARB_STARVE_GUARD_EN enables the fetch
// starvation guard; without it arbitration is pure fixed priority.
module rib_arbiter
  import tinyriscv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned ARB_IDLE_BUBBLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [MEM_ADDR_W-1:0] dbg_addr_i,
  input  logic [MEM_W-1:0]      dbg_wdata_i,
  output logic                  dbg_ready_o,

  input  logic                  ex_req_i,
  input  logic                  ex_we_i,
  input  logic [MEM_ADDR_W-1:0] ex_addr_i,
  input  logic [MEM_W-1:0]      ex_wdata_i,
  output logic                  ex_ready_o,

  input  logic                  pc_req_i,
  input  logic [MEM_ADDR_W-1:0] pc_addr_i,
  output logic                  pc_ready_o,

  output logic [MEM_W-1:0]      rdata_o,

  output logic                  s_req_o,
  output logic                  s_we_o,
  output logic [MEM_ADDR_W-1:0] s_addr_o,
  output logic [MEM_W-1:0]      s_wdata_o,
  input  logic [MEM_W-1:0]      s_rdata_i,
  input  logic                  s_ready_i,

  output logic                  hold_flag_o
);

  rib_arb_state_e state_q, state_d;
  rib_owner_e     owner_q, owner_d;
  rib_owner_e     grant;

  logic busy;
  logic done;
  logic dbg_req_m;
  logic ex_req_m;
  logic pc_req_m;
  logic pc_first;

  assign busy = (state_q == BUSY);
  assign done = busy && s_ready_i;

  // A finishing owner still holds its request during its completion cycle;
  // keep it out of the back-to-back pick so the same transaction is not
  // granted twice.
  assign dbg_req_m = dbg_req_i && !(done && owner_q == DBG);
  assign ex_req_m  = ex_req_i  && !(done && owner_q == EX);
  assign pc_req_m  = pc_req_i  && !(done && owner_q == PC);

  rib_arb_prio u_prio (
    .dbg_req_i  (dbg_req_m),
    .ex_req_i   (ex_req_m),
    .pc_req_i   (pc_req_m),
    .pc_first_i (pc_first),
    .grant_o    (grant)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (grant != NONE) begin
          state_d = BUSY;
          owner_d = grant;
        end
      end
      BUSY: begin
        if (s_ready_i) begin
          if (ARB_IDLE_BUBBLE != 0 || grant == NONE) begin
            state_d = IDLE;
            owner_d = NONE;
          end else begin
            owner_d = grant;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Slave-side mux: driven from the owner's live inputs while BUSY
  // ---------------------------------------------------------------------
  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (busy) begin
      s_req_o = 1'b1;
      case (owner_q)
        DBG: begin
          s_we_o    = dbg_we_i;
          s_addr_o  = dbg_addr_i;
          s_wdata_o = dbg_wdata_i;
        end
        EX: begin
          s_we_o    = ex_we_i;
          s_addr_o  = ex_addr_i;
          s_wdata_o = ex_wdata_i;
        end
        PC: begin
          s_addr_o  = pc_addr_i;
        end
        default: begin
          s_we_o    = 1'b0;
        end
      endcase
    end
  end

  assign dbg_ready_o = done && (owner_q == DBG);
  assign ex_ready_o  = done && (owner_q == EX);
  assign pc_ready_o  = done && (owner_q == PC);
  assign rdata_o     = done ? s_rdata_i : '0;
  assign hold_flag_o = (owner_q == DBG) || dbg_req_i;

  // ---------------------------------------------------------------------
  // Fetch starvation guard
  // ---------------------------------------------------------------------
`ifdef RIB_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q;
  logic       grant_fire;

  assign pc_first = (starve_cnt_q >= 4'(STARVE_LIMIT));
  // A new grant is taken whenever the next owner comes from an arbitration:
  // from IDLE, or from a completion cycle in back-to-back mode.
  assign grant_fire = (owner_d != NONE) && (state_q == IDLE || done);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else if (grant_fire) begin
      if (grant == PC || pc_first) begin
        starve_cnt_q <= '0;
      end else if (grant == EX && pc_req_i && starve_cnt_q != '1) begin
        starve_cnt_q <= starve_cnt_q + 4'd1;
      end
    end
  end
`else
  logic [3:0] unused_starve_limit;
  assign unused_starve_limit = 4'(STARVE_LIMIT);
  assign pc_first = 1'b0;
`endif

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter (default parameters: STARVE_LIMIT = 4,
// ARB_IDLE_BUBBLE = 1). Directed scenarios use cycle tables; the random
// scenario runs against a transaction-level reference model of the
// arbitration rules. The starvation scenario runs only when
// RIB_ARB_STARVE_GUARD_EN is defined.
module tb_rib_arbiter;

  localparam int unsigned LIMIT  = 4;
  localparam int unsigned BUBBLE = 1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dbg_req_i, dbg_we_i;
  logic [31:0] dbg_addr_i, dbg_wdata_i;
  logic        dbg_ready_o;
  logic        ex_req_i, ex_we_i;
  logic [31:0] ex_addr_i, ex_wdata_i;
  logic        ex_ready_o;
  logic        pc_req_i;
  logic [31:0] pc_addr_i;
  logic        pc_ready_o;
  logic [31:0] rdata_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [31:0] s_rdata_i;
  logic        s_ready_i;
  logic        hold_flag_o;

  int n_checks = 0;
  int n_fail   = 0;

  rib_arbiter #(
    .STARVE_LIMIT    (LIMIT),
    .ARB_IDLE_BUBBLE (BUBBLE)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .dbg_req_i   (dbg_req_i),
    .dbg_we_i    (dbg_we_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .dbg_ready_o (dbg_ready_o),
    .ex_req_i    (ex_req_i),
    .ex_we_i     (ex_we_i),
    .ex_addr_i   (ex_addr_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_ready_o  (ex_ready_o),
    .pc_req_i    (pc_req_i),
    .pc_addr_i   (pc_addr_i),
    .pc_ready_o  (pc_ready_o),
    .rdata_o     (rdata_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_rdata_i   (s_rdata_i),
    .s_ready_i   (s_ready_i),
    .hold_flag_o (hold_flag_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = '0; dbg_wdata_i = '0;
    ex_req_i  = 0; ex_we_i  = 0; ex_addr_i  = '0; ex_wdata_i  = '0;
    pc_req_i  = 0; pc_addr_i = '0;
    s_ready_i = 0; s_rdata_i = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    s_ready_i = 1'b1;
    s_rdata_i = 32'hCAFE_F00D;
    #3;
    n_checks++;
    if ({s_req_o, s_we_o, dbg_ready_o, ex_ready_o, pc_ready_o, hold_flag_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {s_req_o, s_we_o, dbg_ready_o, ex_ready_o, pc_ready_o, hold_flag_o});
    end
    n_checks++;
    if ({s_addr_o, s_wdata_o, rdata_o} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h required all zero", s_addr_o, s_wdata_o, rdata_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    // stray slave ready while idle must be ignored
    tick();
    @(negedge clk_i);
    n_checks++;
    if ({s_req_o, dbg_ready_o, ex_ready_o, pc_ready_o, rdata_o} !== 36'h0) begin
      n_fail++;
      $display("FAIL idle_stray_ready: req %b readys %b rdata %h required zero",
               s_req_o, {dbg_ready_o, ex_ready_o, pc_ready_o}, rdata_o);
    end
    s_ready_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_pc_read();
    bit          t_pc   [4] = '{1, 1, 1, 0};
    bit          t_rdy  [4] = '{0, 0, 1, 0};
    bit          e_sreq [4] = '{0, 1, 1, 0};
    bit [2:0]    e_rdy  [4] = '{3'b000, 3'b000, 3'b001, 3'b000};
    logic [31:0] e_addr [4] = '{32'h0, 32'h100, 32'h100, 32'h0};
    logic [31:0] e_rdata[4] = '{32'h0, 32'h0, 32'h13, 32'h0};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      pc_req_i  = t_pc[c];
      pc_addr_i = 32'h0000_0100;
      s_ready_i = t_rdy[c];
      s_rdata_i = t_rdy[c] ? 32'h0000_0013 : 32'hFFFF_FFFF;
      @(negedge clk_i);
      n_checks++;
      if (s_req_o !== e_sreq[c] || s_we_o !== 1'b0) begin
        n_fail++;
        $display("FAIL pc_read_req c%0d: req %b we %b required req %b we 0", c, s_req_o, s_we_o, e_sreq[c]);
      end
      n_checks++;
      if ({dbg_ready_o, ex_ready_o, pc_ready_o} !== e_rdy[c]) begin
        n_fail++;
        $display("FAIL pc_read_ready c%0d: got %b required %b", c, {dbg_ready_o, ex_ready_o, pc_ready_o}, e_rdy[c]);
      end
      n_checks++;
      if (s_addr_o !== e_addr[c] || rdata_o !== e_rdata[c]) begin
        n_fail++;
        $display("FAIL pc_read_data c%0d: addr %h rdata %h required %h %h", c, s_addr_o, rdata_o, e_addr[c], e_rdata[c]);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_ex_pc_same_cycle();
    bit          t_ex   [5] = '{1, 1, 0, 0, 0};
    bit          t_pc   [5] = '{1, 1, 1, 1, 0};
    bit          t_rdy  [5] = '{0, 1, 0, 1, 0};
    bit          e_sreq [5] = '{0, 1, 0, 1, 0};
    bit          e_we   [5] = '{0, 1, 0, 0, 0};
    bit [2:0]    e_rdy  [5] = '{3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
    logic [31:0] e_addr [5] = '{32'h0, 32'h2000_0040, 32'h0, 32'h0000_0200, 32'h0};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      ex_req_i = t_ex[c]; ex_we_i = 1'b1; ex_addr_i = 32'h2000_0040; ex_wdata_i = 32'h1234_5678;
      pc_req_i = t_pc[c]; pc_addr_i = 32'h0000_0200;
      s_ready_i = t_rdy[c];
      s_rdata_i = 32'hA000_0000 + 32'(c);
      @(negedge clk_i);
      n_checks++;
      if (s_req_o !== e_sreq[c] || s_we_o !== e_we[c] || s_addr_o !== e_addr[c]) begin
        n_fail++;
        $display("FAIL ex_pc_slave c%0d: req %b we %b addr %h required %b %b %h",
                 c, s_req_o, s_we_o, s_addr_o, e_sreq[c], e_we[c], e_addr[c]);
      end
      n_checks++;
      if ({dbg_ready_o, ex_ready_o, pc_ready_o} !== e_rdy[c]) begin
        n_fail++;
        $display("FAIL ex_pc_ready c%0d: got %b required %b", c, {dbg_ready_o, ex_ready_o, pc_ready_o}, e_rdy[c]);
      end
      if (c == 1) begin
        n_checks++;
        if (s_wdata_o !== 32'h1234_5678) begin
          n_fail++;
          $display("FAIL ex_pc_wdata: got %h required 12345678", s_wdata_o);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_dbg_during_pc();
    bit          t_pc   [7] = '{1, 1, 1, 0, 0, 0, 0};
    bit          t_dbg  [7] = '{0, 1, 1, 1, 1, 1, 0};
    bit          t_rdy  [7] = '{0, 0, 1, 0, 0, 1, 0};
    bit          e_sreq [7] = '{0, 1, 1, 0, 1, 1, 0};
    bit          e_hold [7] = '{0, 1, 1, 1, 1, 1, 0};
    bit [2:0]    e_rdy  [7] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b000};
    logic [31:0] e_addr [7] = '{32'h0, 32'h100, 32'h100, 32'h0, 32'h1000_0000, 32'h1000_0000, 32'h0};
    logic [31:0] e_wd   [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      tick();
      pc_req_i  = t_pc[c];  pc_addr_i = 32'h0000_0100;
      dbg_req_i = t_dbg[c]; dbg_we_i = 1'b1; dbg_addr_i = 32'h1000_0000; dbg_wdata_i = 32'hDEAD_BEEF;
      s_ready_i = t_rdy[c];
      s_rdata_i = 32'h0000_0013;
      @(negedge clk_i);
      n_checks++;
      if (hold_flag_o !== e_hold[c]) begin
        n_fail++;
        $display("FAIL dbg_hold c%0d: got %b required %b", c, hold_flag_o, e_hold[c]);
      end
      n_checks++;
      if (s_req_o !== e_sreq[c] || s_addr_o !== e_addr[c] || s_wdata_o !== e_wd[c]) begin
        n_fail++;
        $display("FAIL dbg_slave c%0d: req %b addr %h wdata %h required %b %h %h",
                 c, s_req_o, s_addr_o, s_wdata_o, e_sreq[c], e_addr[c], e_wd[c]);
      end
      n_checks++;
      if ({dbg_ready_o, ex_ready_o, pc_ready_o} !== e_rdy[c]) begin
        n_fail++;
        $display("FAIL dbg_ready c%0d: got %b required %b", c, {dbg_ready_o, ex_ready_o, pc_ready_o}, e_rdy[c]);
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset_mid_tx();
    bit seen_ready;
    apply_reset();
    tick();
    ex_req_i = 1'b1; ex_we_i = 1'b1; ex_addr_i = 32'h2000_0000; ex_wdata_i = 32'h55AA_55AA;
    @(negedge clk_i);
    tick();
    @(negedge clk_i);
    n_checks++;
    if (s_req_o !== 1'b1 || s_we_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_busy: req %b we %b required 1 1", s_req_o, s_we_o);
    end
    #2;
    s_ready_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({s_req_o, s_we_o, ex_ready_o, s_addr_o, s_wdata_o, rdata_o} !== 99'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: req %b we %b ex_ready %b addr %h wdata %h rdata %h required zero",
               s_req_o, s_we_o, ex_ready_o, s_addr_o, s_wdata_o, rdata_o);
    end
    ex_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk_i);
      seen_ready |= ex_ready_o;
    end
    n_checks++;
    if (s_req_o !== 1'b0 || seen_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: req %b ex_ready seen %b required 0 0", s_req_o, seen_ready);
    end
    s_ready_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: highest-priority pending master wins whenever the bus
  // is free; the owner keeps the bus until the slave reports completion.
  function automatic int model_pick(bit d, bit e, bit p, bit pc_first);
    if (d) return 1;
    if (pc_first && p) return 3;
    if (e) return 2;
    if (p) return 3;
    return 0;
  endfunction

  task automatic test_random();
    bit [3:0]    m_req;
    bit [3:0]    m_we;
    logic [31:0] m_addr [4];
    logic [31:0] m_wdata[4];
    int          own;
    int          starve;
    int          g;
    bit          starve_on;
    bit          exp_done;
    bit          arb;
    bit          pc_raw;
    bit          pc_first;
    bit [2:0]    exp_rdy;
`ifdef RIB_ARB_STARVE_GUARD_EN
    starve_on = 1'b1;
`else
    starve_on = 1'b0;
`endif
    m_req = '0; m_we = '0; own = 0; starve = 0;
    for (int m = 0; m < 4; m++) begin
      m_addr[m] = '0; m_wdata[m] = '0;
    end
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      for (int m = 1; m < 4; m++) begin
        if (!m_req[m] && $urandom_range(0, (m == 1) ? 9 : 2) == 0) begin
          m_req[m]   = 1'b1;
          m_we[m]    = (m == 3) ? 1'b0 : 1'($urandom_range(0, 1));
          m_addr[m]  = $urandom;
          m_wdata[m] = (m == 3) ? 32'h0 : $urandom;
        end
      end
      dbg_req_i = m_req[1]; dbg_we_i = m_we[1]; dbg_addr_i = m_addr[1]; dbg_wdata_i = m_wdata[1];
      ex_req_i  = m_req[2]; ex_we_i  = m_we[2]; ex_addr_i  = m_addr[2]; ex_wdata_i  = m_wdata[2];
      pc_req_i  = m_req[3]; pc_addr_i = m_addr[3];
      s_ready_i = (own != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      s_rdata_i = $urandom;
      @(negedge clk_i);
      exp_done = (own != 0) && s_ready_i;
      exp_rdy  = exp_done ? (3'b1 << (3 - own)) : 3'b000;
      n_checks++;
      if (s_req_o !== (own != 0) || s_we_o !== m_we[own] ||
          s_addr_o !== m_addr[own] || s_wdata_o !== m_wdata[own]) begin
        n_fail++;
        $display("FAIL rand_slave cyc%0d: req %b we %b addr %h wdata %h required %b %b %h %h",
                 cyc, s_req_o, s_we_o, s_addr_o, s_wdata_o, (own != 0), m_we[own], m_addr[own], m_wdata[own]);
      end
      n_checks++;
      if ({dbg_ready_o, ex_ready_o, pc_ready_o} !== exp_rdy ||
          rdata_o !== (exp_done ? s_rdata_i : 32'h0)) begin
        n_fail++;
        $display("FAIL rand_ready cyc%0d: readys %b rdata %h required %b %h",
                 cyc, {dbg_ready_o, ex_ready_o, pc_ready_o}, rdata_o, exp_rdy, exp_done ? s_rdata_i : 32'h0);
      end
      n_checks++;
      if (hold_flag_o !== ((own == 1) || m_req[1])) begin
        n_fail++;
        $display("FAIL rand_hold cyc%0d: got %b required %b", cyc, hold_flag_o, (own == 1) || m_req[1]);
      end
      // advance the model to the next cycle
      pc_raw = m_req[3];
      arb    = 1'b0;
      if (own == 0) begin
        arb = 1'b1;
      end else if (exp_done) begin
        m_req[own] = 1'b0;
        own = 0;
        arb = (BUBBLE == 0);
      end
      if (arb) begin
        pc_first = starve_on && (starve >= int'(LIMIT));
        g = model_pick(m_req[1], m_req[2], m_req[3], pc_first);
        if (g != 0) begin
          own = g;
          if (g == 3 || pc_first) starve = 0;
          else if (g == 2 && pc_raw && starve < 15) starve++;
        end
      end
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------
`ifdef RIB_ARB_STARVE_GUARD_EN
  task automatic test_starve_guard();
    int exp_seq [10] = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3};
    int got_seq [$];
    int who;
    apply_reset();
    for (int cyc = 0; cyc < 80 && got_seq.size() < 10; cyc++) begin
      tick();
      ex_req_i = 1'b1; ex_addr_i = 32'h2000_0000; ex_we_i = 1'b0;
      pc_req_i = 1'b1; pc_addr_i = 32'h0000_0000;
      s_ready_i = s_req_o;
      s_rdata_i = 32'h0;
      @(negedge clk_i);
      who = dbg_ready_o ? 1 : ex_ready_o ? 2 : pc_ready_o ? 3 : 0;
      if (who != 0) got_seq.push_back(who);
    end
    n_checks++;
    if (got_seq.size() != 10) begin
      n_fail++;
      $display("FAIL starve_budget: completions %0d required 10", got_seq.size());
    end
    for (int i = 0; i < got_seq.size(); i++) begin
      n_checks++;
      if (got_seq[i] != exp_seq[i]) begin
        n_fail++;
        $display("FAIL starve_order[%0d]: owner %0d required %0d (1=dbg 2=ex 3=pc)", i, got_seq[i], exp_seq[i]);
      end
    end
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    rst_ni = 1'b1;
    test_reset();
    test_pc_read();
    test_ex_pc_same_cycle();
    test_dbg_during_pc();
    test_reset_mid_tx();
    test_random();
`ifdef RIB_ARB_STARVE_GUARD_EN
    test_starve_guard();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
